// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow clock in input_clock cycles, with stop-timeout.
// Define CLOCK_PERIOD_METER_AVERAGE_EN to report the average of every 4 consecutive periods.
module clock_period_meter #(
  parameter int unsigned COUNTER_WIDTH  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                     input_clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     measured_clock,
  output logic [COUNTER_WIDTH-1:0] period,
  output logic [COUNTER_WIDTH-1:0] high_time,
  output logic                     period_valid,
  output logic                     timeout
);

  typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE} state_t;

  localparam logic [COUNTER_WIDTH-1:0] TIMEOUT_VAL = COUNTER_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [COUNTER_WIDTH-1:0] ONE         = COUNTER_WIDTH'(1);

  state_t                   state_q;
  logic                     sync1_q, sync2_q, dly_q;
  logic [COUNTER_WIDTH-1:0] counter_q, counter_d;
  logic [COUNTER_WIDTH-1:0] hcnt_q;
  logic [COUNTER_WIDTH-1:0] period_q, high_q;
  logic                     valid_q, timeout_q;
  logic                     rise, fall;

`ifdef CLOCK_PERIOD_METER_AVERAGE_EN
  logic [COUNTER_WIDTH+1:0] acc_q, acc_d, hacc_q, hacc_d;
  logic [1:0]               sub_q;

  always_comb begin
    acc_d  = acc_q + {2'b00, counter_q};
    hacc_d = hacc_q + {2'b00, hcnt_q};
  end
`endif

  always_comb begin
    rise      = sync2_q & ~dly_q;
    fall      = ~sync2_q & dly_q;
    counter_d = (counter_q == '1) ? counter_q : counter_q + ONE;
  end

  always_ff @(posedge input_clock) begin
    if (reset) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      dly_q     <= 1'b0;
      counter_q <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
`ifdef CLOCK_PERIOD_METER_AVERAGE_EN
      acc_q     <= '0;
      hacc_q    <= '0;
      sub_q     <= '0;
`endif
    end else begin
      sync1_q <= measured_clock;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
      valid_q <= 1'b0;
      if (!enable) begin
        state_q   <= IDLE;
        counter_q <= '0;
        timeout_q <= 1'b0;
`ifdef CLOCK_PERIOD_METER_AVERAGE_EN
        acc_q     <= '0;
        hacc_q    <= '0;
        sub_q     <= '0;
`endif
      end else begin
        case (state_q)
          IDLE: begin
            counter_q <= '0;
            state_q   <= WAIT_EDGE;
          end
          WAIT_EDGE: begin
            if (rise) begin
              counter_q <= ONE;
              state_q   <= MEASURE;
            end else begin
              counter_q <= counter_d;
            end
          end
          MEASURE: begin
            // A rising edge on the threshold cycle takes priority over the timeout.
            if (rise) begin
              counter_q <= ONE;
              timeout_q <= 1'b0;
`ifdef CLOCK_PERIOD_METER_AVERAGE_EN
              if (sub_q == 2'd3) begin
                period_q <= acc_d[COUNTER_WIDTH+1:2];
                high_q   <= hacc_d[COUNTER_WIDTH+1:2];
                valid_q  <= 1'b1;
                acc_q    <= '0;
                hacc_q   <= '0;
                sub_q    <= '0;
              end else begin
                acc_q    <= acc_d;
                hacc_q   <= hacc_d;
                sub_q    <= sub_q + 2'd1;
              end
`else
              period_q <= counter_q;
              high_q   <= hcnt_q;
              valid_q  <= 1'b1;
`endif
            end else begin
              counter_q <= counter_d;
              if (fall) hcnt_q <= counter_q;
              if (counter_q == TIMEOUT_VAL) begin
                timeout_q <= 1'b1;
                state_q   <= WAIT_EDGE;
`ifdef CLOCK_PERIOD_METER_AVERAGE_EN
                acc_q     <= '0;
                hacc_q    <= '0;
                sub_q     <= '0;
`endif
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign period       = period_q;
  assign high_time    = high_q;
  assign period_valid = valid_q;
  assign timeout      = timeout_q;

endmodule
